priority_encoder: RTL and testbench

- Registered N-to-log2(N) priority encoder; default configuration is 8 inputs to a 3-bit index.
- Reports the index of the highest-numbered asserted request bit, plus a valid flag indicating at least one request is set.
- Used as an arbitration/index front-end for request vectors.
- Outputs are registered once on the clock.

---
 rtl/priority_encoder.sv | 39 +++
 tb/tb_priority_encoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// Registered priority encoder: reports the index of the highest set request bit
// together with a valid flag, one clock after sampling.
module priority_encoder #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] next_out;
    logic             next_valid;

    // Ascending scan: later (higher) set bits overwrite earlier ones, so the MSB wins.
    always_comb begin
        next_out   = '0;
        next_valid = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                next_out   = OUT_W'(i);
                next_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= next_out;
            valid <= next_valid;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed table, latency and reset
// sequences, exhaustive sweep and random vectors against an arithmetic model.
module tb_priority_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] out;
    logic       valid;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] din;
        logic [2:0] eout;
        logic       evalid;
    } vec_t;

    vec_t tbl[11];

    priority_encoder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (din),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Index of the most significant set bit, by repeated halving.
    function automatic logic [2:0] ref_idx(input int v);
        int idx = 0;
        while (v > 1) begin
            v = v / 2;
            idx++;
        end
        return 3'(idx);
    endfunction

    task automatic check(input string name, input logic [2:0] eout, input logic evalid);
        vectors++;
        if (out !== eout || valid !== evalid) begin
            miscompares++;
            $display("FAIL %s: got out=%0d valid=%0b, expected out=%0d valid=%0b",
                     name, out, valid, eout, evalid);
        end
    endtask

    task automatic apply(input logic [7:0] v);
        @(negedge clk);
        din = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{8'b0000_0000, 3'd0, 1'b0};
        tbl[1]  = '{8'b0000_0001, 3'd0, 1'b1};
        tbl[2]  = '{8'b0000_0010, 3'd1, 1'b1};
        tbl[3]  = '{8'b0000_0100, 3'd2, 1'b1};
        tbl[4]  = '{8'b0001_0000, 3'd4, 1'b1};
        tbl[5]  = '{8'b0010_0000, 3'd5, 1'b1};
        tbl[6]  = '{8'b1000_0000, 3'd7, 1'b1};
        tbl[7]  = '{8'b0000_1010, 3'd3, 1'b1};
        tbl[8]  = '{8'b0100_0100, 3'd6, 1'b1};
        tbl[9]  = '{8'b0011_0000, 3'd5, 1'b1};
        tbl[10] = '{8'b1001_0001, 3'd7, 1'b1};

        // Reset: outputs clear immediately, stay clear across edges while held.
        din = 8'hFF;
        #1 rst = 1'b1;
        #1 check("reset_immediate", 3'd0, 1'b0);
        @(posedge clk); #1;
        check("reset_held", 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release_first_edge", 3'd7, 1'b1);

        // Directed table.
        foreach (tbl[i]) begin
            apply(tbl[i].din);
            check($sformatf("table_%0d", i), tbl[i].eout, tbl[i].evalid);
        end

        // Latency: mid-cycle change must not show until the next rising edge.
        apply(8'b0000_0001);
        check("latency_before", 3'd0, 1'b1);
        @(negedge clk);
        din = 8'b1000_0000;
        #1 check("latency_midcycle_hold", 3'd0, 1'b1);
        @(posedge clk); #1;
        check("latency_after_edge", 3'd7, 1'b1);

        // Exhaustive sweep on consecutive cycles.
        for (int v = 0; v < 256; v++) begin
            apply(8'(v));
            check($sformatf("sweep_%0d", v), ref_idx(v), v != 0);
        end

        // Random vectors.
        for (int k = 0; k < 150; k++) begin
            automatic int r = int'($urandom_range(255, 0));
            apply(8'(r));
            check($sformatf("rand_%0d_in_%0h", k, r), ref_idx(r), r != 0);
        end

        // Async reset mid-stream.
        apply(8'b1000_0000);
        check("mid_reset_before", 3'd7, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("mid_reset_immediate", 3'd0, 1'b0);
        @(posedge clk); #1;
        check("mid_reset_edge_discarded", 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        din = 8'b0000_1010;
        @(posedge clk); #1;
        check("mid_reset_resume", 3'd3, 1'b1);
        apply(8'b0000_0000);
        check("mid_reset_resume_zero", 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
